// File: rtl/cpu_bus_master.sv
// Host bus master: turns a CPU request into one phi3-aligned memory cycle of one
// or two byte phases, and serializes the latched address for an external receiver.
module cpu_bus_master #(
  parameter int unsigned PHI_DIV     = 4,
  parameter int unsigned ADDR_CYCLES = 40,
  parameter int unsigned BYTE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        rnw,
  input  logic        byte_en,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        phi3,
  output logic        memen,
  output logic        dbin,
  output logic        we,
  output logic        a15,
  inout  wire  [7:0]  data_bus,
  input  logic        shld,
  input  logic        serclk,
  output logic        adrin1,
  output logic        adrin2
);

  localparam int unsigned Period = 4 * PHI_DIV;
  localparam int unsigned PhW    = $clog2(Period);

  localparam logic [15:0] AddrLast = 16'(ADDR_CYCLES - 1);
  localparam logic [15:0] ByteLast = 16'(BYTE_CYCLES - 1);
  localparam logic [15:0] WeLast   = 16'(BYTE_CYCLES - 2);
  localparam logic [15:0] EndLast  = 16'(PHI_DIV - 1);

  typedef enum logic [2:0] {StIdle, StSync, StAddr, StByteHi, StByteLo, StEnd} state_e;

  state_e         st_q, st_d;
  logic [15:0]    cyc_q, cyc_d;
  logic [PhW-1:0] phi_cnt_q, phi_cnt_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           rnw_q, rnw_d;
  logic           byte_en_q, byte_en_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           memen_q, memen_d;
  logic           dbin_q, dbin_d;
  logic           we_q, we_d;
  logic           a15_q, a15_d;
  logic           oe_q, oe_d;
  logic [7:0]     dout_q, dout_d;
  logic [7:0]     sr1_q, sr1_d;
  logic [7:0]     sr2_q, sr2_d;
  logic           serclk_q;
  logic           phi_fall;
  logic           in_phase;

  // Free-running phi3 divider; phi_fall marks the cycle whose end drops phi3.
  always_comb begin
    phi_cnt_d = (phi_cnt_q == PhW'(Period - 1)) ? '0 : phi_cnt_q + 1'b1;
    phi_fall  = (phi_cnt_q == PhW'(Period - 1));
  end

  // Transaction sequencing; outputs are derived from the next state so they register cleanly.
  always_comb begin
    st_d      = st_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rnw_d     = rnw_q;
    byte_en_d = byte_en_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (req) begin
          addr_d    = addr;
          wdata_d   = wdata;
          rnw_d     = rnw;
          byte_en_d = byte_en;
          st_d      = StSync;
          cyc_d     = '0;
        end
      end
      StSync: begin
        if (phi_fall) begin
          st_d  = StAddr;
          cyc_d = '0;
        end
      end
      StAddr: begin
        if (cyc_q == AddrLast) begin
          cyc_d = '0;
          st_d  = (byte_en_q && addr_q[0]) ? StByteLo : StByteHi;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StByteHi: begin
        if (cyc_q == ByteLast) begin
          if (rnw_q) rdata_d[15:8] = data_bus;
          cyc_d = '0;
          st_d  = byte_en_q ? StEnd : StByteLo;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StByteLo: begin
        if (cyc_q == ByteLast) begin
          if (rnw_q) rdata_d[7:0] = data_bus;
          cyc_d = '0;
          st_d  = StEnd;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      StEnd: begin
        if (cyc_q == EndLast) begin
          st_d   = StIdle;
          cyc_d  = '0;
          done_d = 1'b1;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: st_d = StIdle;
    endcase

    in_phase = (st_d == StByteHi) || (st_d == StByteLo);
    busy_d   = (st_d != StIdle);
    memen_d  = !((st_d == StAddr) || in_phase);
    dbin_d   = !memen_d && rnw_d;
    a15_d    = (st_d == StByteLo);
    oe_d     = in_phase && !rnw_d;
    // Write strobe sits inside the phase so data is settled on both of its edges.
    we_d     = oe_d && (cyc_d >= 16'd2) && (cyc_d <= WeLast);
    dout_d   = (st_d == StByteLo) ? wdata_d[7:0] : wdata_d[15:8];
  end

  // Address serializer: reload while shld is low, shift on each registered serclk fall.
  always_comb begin
    sr1_d = sr1_q;
    sr2_d = sr2_q;
    if (!shld) begin
      sr1_d = addr_q[15:8];
      sr2_d = addr_q[7:0];
    end else if (serclk_q && !serclk) begin
      sr1_d = {sr1_q[6:0], 1'b0};
      sr2_d = {sr2_q[6:0], 1'b0};
    end
  end

  // Bus FSM, divider and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= StIdle;
      cyc_q     <= '0;
      phi_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rnw_q     <= 1'b0;
      byte_en_q <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      memen_q   <= 1'b1;
      dbin_q    <= 1'b0;
      we_q      <= 1'b0;
      a15_q     <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= '0;
    end else begin
      st_q      <= st_d;
      cyc_q     <= cyc_d;
      phi_cnt_q <= phi_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rnw_q     <= rnw_d;
      byte_en_q <= byte_en_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      memen_q   <= memen_d;
      dbin_q    <= dbin_d;
      we_q      <= we_d;
      a15_q     <= a15_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
    end
  end

  // Serializer state and serclk edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr1_q    <= '0;
      sr2_q    <= '0;
      serclk_q <= 1'b0;
    end else begin
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      serclk_q <= serclk;
    end
  end

  assign data_bus = oe_q ? dout_q : 8'hzz;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign phi3     = (phi_cnt_q >= PhW'(PHI_DIV));
  assign memen    = memen_q;
  assign dbin     = dbin_q;
  assign we       = we_q;
  assign a15      = a15_q;
  assign adrin1   = sr1_q[7];
  assign adrin2   = sr2_q[7];

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: bus timing, read/write data, reset abort,
// ignored requests and address serializer loopback.
module tb_cpu_bus_master;

  localparam int PD = 4;
  localparam int AC = 40;
  localparam int BC = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req = 1'b0;
  logic        rnw = 1'b0;
  logic        byte_en = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, done, phi3, memen, dbin, we, a15;
  logic [15:0] rdata;
  wire  [7:0]  data_bus;
  logic        shld = 1'b0;
  logic        serclk = 1'b0;
  logic        adrin1, adrin2;

  // Bus model: returns read data while a read cycle is active, otherwise parks 8'h00
  // on the bus unless a write phase is expected.
  logic        tb_release = 1'b0;
  logic [7:0]  rd_hi_v = '0;
  logic [7:0]  rd_lo_v = '0;
  assign data_bus = tb_release ? 8'hzz :
                    ((!memen && dbin) ? (a15 ? rd_lo_v : rd_hi_v) : 8'h00);

  int n_checks = 0;
  int n_errors = 0;

  cpu_bus_master #(
    .PHI_DIV    (PD),
    .ADDR_CYCLES(AC),
    .BYTE_CYCLES(BC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .rnw     (rnw),
    .byte_en (byte_en),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .phi3    (phi3),
    .memen   (memen),
    .dbin    (dbin),
    .we      (we),
    .a15     (a15),
    .data_bus(data_bus),
    .shld    (shld),
    .serclk  (serclk),
    .adrin1  (adrin1),
    .adrin2  (adrin2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One full transaction, checked cycle by cycle relative to the memen fall.
  task automatic run_txn(input string tag, input logic r, input logic be,
                         input logic [15:0] ad, input logic [15:0] wd,
                         input logic pulse_extra);
    int nph, win, p, j;
    int bad_memen, bad_a15, bad_we, bad_bus, bad_end, n_we, dones, done_at, extra;
    logic prev_phi, seen, busy_at_done, lo, exp_we;
    logic [7:0] exp_bus;
    nph = be ? 1 : 2;
    win = AC + nph * BC;
    bad_memen = 0; bad_a15 = 0; bad_we = 0; bad_bus = 0; bad_end = 0;
    n_we = 0; dones = 0; done_at = -1; extra = 0; busy_at_done = 1'b1;

    @(negedge clk);
    rnw = r; byte_en = be; addr = ad; wdata = wd; req = 1'b1;
    @(negedge clk);
    // Scramble inputs to prove the transaction uses latched copies.
    req = 1'b0; rnw = ~r; byte_en = ~be; addr = ~ad; wdata = ~wd;
    check({tag, "_busy"}, 32'(busy), 32'd1);

    prev_phi = phi3;
    seen = 1'b0;
    for (int t = 0; t < 4 * PD + 4 && !seen; t++) begin
      @(negedge clk);
      if (!memen) seen = 1'b1;
      else prev_phi = phi3;
    end
    check({tag, "_memen_fall"}, 32'(seen), 32'd1);
    check({tag, "_phi_align"}, 32'({prev_phi, phi3}), 32'b10);

    for (int k = 0; k < win; k++) begin
      if (k > 0) @(negedge clk);
      if (k < AC) begin
        lo = 1'b0;
        exp_we = 1'b0;
      end else begin
        p = (k - AC) / BC;
        j = (k - AC) % BC;
        lo = (p == 0) ? (be ? ad[0] : 1'b0) : 1'b1;
        exp_we = !r && (j >= 2) && (j <= BC - 2);
      end
      exp_bus = (k >= AC) ? (lo ? wd[7:0] : wd[15:8]) : 8'h00;
      if (memen !== 1'b0 || dbin !== r) bad_memen++;
      if (a15 !== lo) bad_a15++;
      if (we !== exp_we) bad_we++;
      if (we === 1'b1) n_we++;
      if (!r && data_bus !== exp_bus) bad_bus++;
      if (done) dones++;
      if (pulse_extra && (k == 5 || k == AC + 2)) begin
        req = 1'b1;
        addr = 16'h1111;
      end else begin
        req = 1'b0;
      end
      tb_release = !r && (k + 1 >= AC) && (k + 1 < win);
    end

    for (int e = 0; e < PD + 4; e++) begin
      @(negedge clk);
      if (e < PD && (memen !== 1'b1 || we !== 1'b0 || a15 !== 1'b0 || dbin !== 1'b0 ||
                     data_bus !== 8'h00)) bad_end++;
      if (done) begin
        dones++;
        done_at = e;
        busy_at_done = busy;
      end
    end

    check({tag, "_memen_dbin"}, 32'(bad_memen), 32'd0);
    check({tag, "_a15"}, 32'(bad_a15), 32'd0);
    check({tag, "_we_timing"}, 32'(bad_we), 32'd0);
    check({tag, "_we_count"}, 32'(n_we), r ? 32'd0 : 32'(nph * (BC - 3)));
    if (!r) check({tag, "_wr_bus"}, 32'(bad_bus), 32'd0);
    check({tag, "_end_phase"}, 32'(bad_end), 32'd0);
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_done_pos"}, 32'(done_at), 32'(PD));
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);

    if (pulse_extra) begin
      for (int t = 0; t < AC + 12 * PD; t++) begin
        @(negedge clk);
        if (memen !== 1'b1 || done !== 1'b0 || busy !== 1'b0) extra++;
      end
      check({tag, "_ignored_req"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi, lo_cnt, dn;
    logic seen;
    logic [7:0] rx1, rx2;

    // Reset state.
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memen", 32'(memen), 32'd1);
    check("rst_phi3", 32'(phi3), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_sig", 32'({dbin, we, a15, adrin1, adrin2}), 32'd0);
    check("rst_bus", 32'(data_bus), 32'h00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // phi3 waveform.
    seen = 1'b0;
    for (int t = 0; t < 4 * PD + 2 && !seen; t++) begin
      @(negedge clk);
      if (!phi3) seen = 1'b1;
    end
    seen = 1'b0;
    for (int t = 0; t < 4 * PD + 2 && !seen; t++) begin
      @(negedge clk);
      if (phi3) seen = 1'b1;
    end
    hi = 0;
    do begin hi++; @(negedge clk); end while (phi3 && hi < 40);
    lo_cnt = 0;
    do begin lo_cnt++; @(negedge clk); end while (!phi3 && lo_cnt < 40);
    check("phi3_high", 32'(hi), 32'(3 * PD));
    check("phi3_low", 32'(lo_cnt), 32'(PD));

    // Word read.
    rd_hi_v = 8'hA5; rd_lo_v = 8'h3C;
    run_txn("rd_word", 1'b1, 1'b0, 16'h6002, 16'h0000, 1'b0);
    check("rd_word_rdata", 32'(rdata), 32'hA53C);

    // Byte read of the odd byte keeps the even byte.
    rd_hi_v = 8'hEE; rd_lo_v = 8'h77;
    run_txn("rd_byte", 1'b1, 1'b1, 16'h6003, 16'h0000, 1'b0);
    check("rd_byte_rdata", 32'(rdata), 32'hA577);

    // Word write with requests pulsed while busy.
    run_txn("wr_word", 1'b0, 1'b0, 16'hA000, 16'h1234, 1'b1);

    // Byte writes: odd byte only, even byte only.
    run_txn("wr_byte_lo", 1'b0, 1'b1, 16'h8301, 16'hFF5A, 1'b0);
    run_txn("wr_byte_hi", 1'b0, 1'b1, 16'h4400, 16'hBE11, 1'b0);
    check("wr_rdata_kept", 32'(rdata), 32'hA577);

    // Serializer loopback with a receiver model sampling on serclk rises.
    rd_hi_v = 8'h11; rd_lo_v = 8'h22;
    run_txn("rd_ser", 1'b1, 1'b0, 16'hC3F0, 16'h0000, 1'b0);
    check("rd_ser_rdata", 32'(rdata), 32'h1122);
    shld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    shld = 1'b1;
    serclk = 1'b0;
    @(negedge clk);
    rx1 = '0;
    rx2 = '0;
    for (int i = 0; i < 8; i++) begin
      serclk = 1'b1;
      rx1 = {rx1[6:0], adrin1};
      rx2 = {rx2[6:0], adrin2};
      @(negedge clk);
      @(negedge clk);
      serclk = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    check("ser_adrin1_seq", 32'(rx1), 32'hC3);
    check("ser_addr", 32'({rx1, rx2}), 32'hC3F0);
    check("ser_drained", 32'({adrin1, adrin2}), 32'd0);
    serclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    serclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ser_still_zero", 32'({adrin1, adrin2}), 32'd0);
    shld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ser_reload", 32'({adrin1, adrin2}), 32'b11);

    // Reset during the even-byte phase of a write.
    @(negedge clk);
    rnw = 1'b0; byte_en = 1'b0; addr = 16'hA000; wdata = 16'h1234; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 4 * PD + 4 && !seen; t++) begin
      @(negedge clk);
      if (!memen) seen = 1'b1;
    end
    check("abort_memen_fall", 32'(seen), 32'd1);
    for (int k = 1; k <= AC + 3; k++) begin
      @(negedge clk);
      if (k == AC - 1) tb_release = 1'b1;
    end
    check("abort_pre_we", 32'(we), 32'd1);
    check("abort_pre_bus", 32'(data_bus), 32'h12);
    #2;
    reset_n = 1'b0;
    tb_release = 1'b0;
    #1;
    check("abort_memen", 32'(memen), 32'd1);
    check("abort_we", 32'(we), 32'd0);
    check("abort_bus", 32'(data_bus), 32'h00);
    check("abort_state", 32'({busy, done, a15, dbin}), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    dn = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (done) dn++;
    end
    reset_n = 1'b1;
    for (int t = 0; t < 8 * PD + AC; t++) begin
      @(negedge clk);
      if (done || busy || !memen) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);

    // Fresh read after the abort.
    rd_hi_v = 8'h5A; rd_lo_v = 8'hC3;
    run_txn("rd_after_rst", 1'b1, 1'b0, 16'h6002, 16'h0000, 1'b0);
    check("rd_after_rst_rdata", 32'(rdata), 32'h5AC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
